det_matrix_loader: RTL and testbench
====================================

Name: det_matrix_loader

Overview:
- Upstream feeder for the 5x5 determinant unit.
- Accepts one NxN matrix (N = 2..5) as a row-major stream of signed 8-bit elements over a valid/ready handshake.
- Embeds the matrix in the top-left of a 5x5 identity, so det(5x5) = det(NxN), and drives the 200-bit flat matrix bus.
- Waits a fixed latency, then captures the determinant and overflow flag returned by the downstream unit and holds them under a valid/ready result handshake.

Parameters:
- DET_LATENCY, 2, clock cycles from the final A_flat update to a valid det/overflow at the downstream outputs; legal range 1..15.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a new matrix; sampled only in IDLE
- mat_size  in  3  matrix order N, sampled with start; legal values 2..5
- busy  out  1  high in every state except IDLE
- size_error  out  1  one-cycle pulse when start arrives with an illegal mat_size
- in_valid  in  1  element stream valid
- in_ready  out  1  element stream ready; high only in LOAD
- in_data  in  8  signed element, row-major order
- A_flat  out  200  flat matrix to the determinant unit; element (r,c) at bits [8*(5r+c)+7 : 8*(5r+c)]
- det_in  in  8  determinant low byte from the determinant unit
- ovf_in  in  1  overflow flag from the determinant unit
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_det  out  8  captured determinant
- res_overflow  out  1  captured overflow flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - A_flat is the 5x5 identity: 0x01 at indices 0, 6, 12, 18, 24, zero elsewhere.
  - busy, in_ready, res_valid, size_error, res_det and res_overflow are all 0.
  - Reset in any state aborts the operation and restores these values on the next edge.
- IDLE:
  - start with mat_size in 2..5: latch N, reset A_flat to identity, clear row/col counters, go to LOAD.
  - start with mat_size 0, 1, 6 or 7: size_error=1 for exactly one cycle, remain in IDLE, A_flat unchanged.
- LOAD:
  - in_ready=1. Each cycle with in_valid&in_ready writes in_data to A_flat index row*5+col.
  - col increments; when col==N-1, col wraps to 0 and row increments.
  - Gaps with in_valid=0 do not advance the counters.
  - On accepting element (N-1, N-1): go to SETTLE, in_ready drops on the following cycle, and the settle counter loads DET_LATENCY.
  - Exactly N*N handshakes are accepted. Elements outside the NxN block keep their identity values.
- SETTLE:
  - A_flat is held stable; the counter decrements each cycle.
  - On reaching 0: capture det_in into res_det and ovf_in into res_overflow, set res_valid=1, go to RESULT.
  - The total capture point is DET_LATENCY+1 edges after the last accepted element.
- RESULT:
  - res_valid=1; res_det and res_overflow are held stable.
  - On res_valid&res_ready: clear res_valid and go to IDLE.
  - A_flat keeps the last matrix until the next valid start.
- start is ignored in every state other than IDLE; it is not queued. size_error is never asserted outside IDLE.
- in_valid outside LOAD is ignored.
- If start and res_ready arrive in the same cycle in RESULT, the result handshake completes and start is ignored. The next start is honoured from IDLE.
- No arithmetic on data; the elements are passed through bit-exact.

Decomposition:
- Shared package det_pkg:
  - state enum {IDLE, LOAD, SETTLE, RESULT}
  - MAT_DIM=5, ELEM_W=8, FLAT_W=200
  - MIN_SIZE=2, MAX_SIZE=5
  - identity constant for A_flat
- No sub-module is needed: the counters, index mapping and FSM fit in one module.
- The bench instantiates det_matrix_loader with a behavioural determinant stub. The stub computes the exact 5x5 determinant, drives its low byte and a flag for values outside -128..127, and applies a configurable latency that matches DET_LATENCY.

Test Plan:
- Reset, then start with mat_size=2 and stream 3, 1, 2, 4 -> A_flat indices 0, 1, 5, 6 hold 3, 1, 2, 4, indices 12, 18, 24 hold 1, all others 0; res_det=10 (0x0A), res_overflow=0, res_valid exactly DET_LATENCY+1 cycles after the 4th handshake.
- start with mat_size=5 and 25 elements forming the identity -> res_det=1, res_overflow=0; start while busy is ignored and busy remains 1.
- start with mat_size=3 and diagonal 10, 10, 10 (other elements 0) -> res_det=0xE8 (-24), res_overflow=1.
- start with mat_size=4, in_valid toggling every other cycle, and res_ready held low 5 cycles -> exactly 16 elements accepted, res_det/res_overflow stable while res_valid=1, IDLE on the cycle after res_ready rises.
- start with mat_size=1, then mat_size=6 -> size_error one-cycle pulse each time, busy=0, in_ready=0, A_flat unchanged.
- Reset asserted after 7 of 9 elements (N=3) -> next edge gives IDLE, A_flat=identity, all outputs 0; a following full 2x2 load completes correctly.

Source files
------------

// File: rtl/det_pkg.sv
// Shared types and constants for the determinant-unit matrix loader.
package det_pkg;

    localparam int unsigned MAT_DIM  = 5;
    localparam int unsigned ELEM_W   = 8;
    localparam int unsigned FLAT_W   = MAT_DIM * MAT_DIM * ELEM_W;
    localparam int unsigned MIN_SIZE = 2;
    localparam int unsigned MAX_SIZE = 5;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RESULT = 2'd3
    } state_t;

    // 5x5 identity laid out on the flat bus, element (r,c) at byte 5r+c.
    function automatic logic [FLAT_W-1:0] identity_flat();
        logic [FLAT_W-1:0] m;
        m = '0;
        for (int unsigned r = 0; r < MAT_DIM; r++) begin
            m[ELEM_W*(MAT_DIM*r + r) +: ELEM_W] = ELEM_W'(1);
        end
        return m;
    endfunction

    localparam logic [FLAT_W-1:0] A_IDENTITY = identity_flat();

    // True for matrix orders the determinant unit can handle.
    function automatic logic size_legal(input logic [SIZE_W-1:0] s);
        return (s >= SIZE_W'(MIN_SIZE)) && (s <= SIZE_W'(MAX_SIZE));
    endfunction

endpackage

// File: rtl/det_matrix_loader.sv
// Streams an NxN matrix into the top-left of a 5x5 identity, waits for the
// determinant unit to settle, then holds its result under a ready/valid handshake.
module det_matrix_loader
    import det_pkg::*;
#(
    parameter int unsigned DET_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        mat_size,
    output logic              busy,
    output logic              size_error,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic [199:0]      A_flat,
    input  logic [7:0]        det_in,
    input  logic              ovf_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_det,
    output logic              res_overflow
);

    state_t              state_q;
    state_t              state_d;
    logic [SIZE_W-1:0]   n_q;
    logic [SIZE_W-1:0]   row_q;
    logic [SIZE_W-1:0]   col_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                start_ok;
    logic                start_bad;
    logic                accept;
    logic                last_elem;
    logic                capture;
    logic [IDX_W-1:0]    elem_idx;

    // Flat-bus byte index of the element currently being written.
    assign elem_idx  = IDX_W'(row_q) * IDX_W'(MAT_DIM) + IDX_W'(col_q);
    assign last_elem = (row_q == n_q - SIZE_W'(1)) && (col_q == n_q - SIZE_W'(1));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_legal(mat_size)) begin
                        start_ok = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    if (last_elem) begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (res_valid && res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs, registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy       <= 1'b0;
            in_ready   <= 1'b0;
            size_error <= 1'b0;
        end else begin
            busy       <= (state_d != IDLE);
            in_ready   <= (state_d == LOAD);
            size_error <= start_bad;
        end
    end

    // Matrix bus and row/column/settle counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            A_flat <= A_IDENTITY;
            n_q    <= '0;
            row_q  <= '0;
            col_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (start_ok) begin
                A_flat <= A_IDENTITY;
                n_q    <= mat_size;
                row_q  <= '0;
                col_q  <= '0;
            end
            if (accept) begin
                A_flat[{elem_idx, 3'b000} +: ELEM_W] <= in_data;
                if (col_q == n_q - SIZE_W'(1)) begin
                    col_q <= '0;
                    row_q <= row_q + SIZE_W'(1);
                end else begin
                    col_q <= col_q + SIZE_W'(1);
                end
                if (last_elem) begin
                    cnt_q <= CNT_W'(DET_LATENCY);
                end
            end
            if ((state_q == SETTLE) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Result capture and hand-off.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_valid    <= 1'b0;
            res_det      <= '0;
            res_overflow <= 1'b0;
        end else begin
            if (capture) begin
                res_valid    <= 1'b1;
                res_det      <= det_in;
                res_overflow <= ovf_in;
            end else if ((state_q == RESULT) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_det_matrix_loader.sv
// Bench for det_matrix_loader with a behavioural 5x5 determinant stub.
module tb_det_matrix_loader;

    localparam int LAT = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   mat_size;
    logic         busy;
    logic         size_error;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic [199:0] A_flat;
    logic [7:0]   det_in;
    logic         ovf_in;
    logic         res_valid;
    logic         res_ready;
    logic [7:0]   res_det;
    logic         res_overflow;

    det_matrix_loader #(.DET_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .mat_size(mat_size),
        .busy(busy), .size_error(size_error), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .A_flat(A_flat),
        .det_in(det_in), .ovf_in(ovf_in), .res_valid(res_valid),
        .res_ready(res_ready), .res_det(res_det), .res_overflow(res_overflow)
    );

    always #5 clock = ~clock;

    // Exact determinant via fraction-free (Bareiss) elimination.
    function automatic longint det5(input logic [199:0] a);
        longint m[5][5];
        longint prev;
        longint sgn;
        longint t;
        int     found;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                m[r][c] = longint'($signed(a[8*(5*r+c) +: 8]));
        prev = 1;
        sgn  = 1;
        for (int k = 0; k < 4; k++) begin
            if (m[k][k] == 0) begin
                found = -1;
                for (int i = k + 1; i < 5; i++)
                    if (found < 0 && m[i][k] != 0) found = i;
                if (found < 0) return 0;
                for (int j = 0; j < 5; j++) begin
                    t = m[k][j]; m[k][j] = m[found][j]; m[found][j] = t;
                end
                sgn = -sgn;
            end
            for (int i = k + 1; i < 5; i++)
                for (int j = k + 1; j < 5; j++)
                    m[i][j] = (m[i][j] * m[k][k] - m[i][k] * m[k][j]) / prev;
            prev = m[k][k];
        end
        return sgn * m[4][4];
    endfunction

    longint     det_now;
    logic [7:0] pd [LAT];
    logic       po [LAT];

    always_comb det_now = det5(A_flat);

    // Stub pipeline: result appears LAT cycles after A_flat changes.
    always_ff @(posedge clock) begin
        pd[0] <= det_now[7:0];
        po[0] <= (det_now > 127) || (det_now < -128);
        for (int i = 1; i < LAT; i++) begin
            pd[i] <= pd[i-1];
            po[i] <= po[i-1];
        end
    end
    assign det_in = pd[LAT-1];
    assign ovf_in = po[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         n;
        logic [7:0] exp_det;
        logic       exp_ovf;
        bit         gap;
        int         hold;
        bit         poke_start;
    } vec_t;

    typedef struct {
        logic [7:0] det;
        logic       ovf;
    } res_t;

    vec_t       vecs[5];
    logic [7:0] el[5][25];
    res_t       sb[$];

    function automatic logic [199:0] ident();
        logic [199:0] m;
        m = '0;
        for (int r = 0; r < 5; r++) m[8*(6*r) +: 8] = 8'd1;
        return m;
    endfunction

    function automatic logic [199:0] embed(input int v);
        logic [199:0] m;
        int n;
        m = ident();
        n = vecs[v].n;
        for (int k = 0; k < n * n; k++) m[8*(5*(k/n) + (k%n)) +: 8] = el[v][k];
        return m;
    endfunction

    // Load one table matrix, check timing, bus contents and the result handshake.
    task automatic run_vec(input int v);
        int   n;
        int   k;
        int   cyc;
        int   lat;
        bit   tog;
        res_t e;
        n   = vecs[v].n;
        k   = 0;
        cyc = 0;
        tog = 1'b0;
        start = 1'b1; mat_size = 3'(n);
        @(negedge clock);
        start = 1'b0;
        check($sformatf("v%0d busy_after_start", v), busy, 1'b1);
        check($sformatf("v%0d in_ready_after_start", v), in_ready, 1'b1);
        check($sformatf("v%0d A_flat_identity_at_start", v), A_flat, ident());
        while (k < n * n && cyc < 200) begin
            tog = !tog;
            in_valid = (vecs[v].gap && !tog) ? 1'b0 : 1'b1;
            in_data  = el[v][k];
            if (vecs[v].poke_start && k == 3) begin
                start = 1'b1; mat_size = 3'd2;
            end else begin
                start = 1'b0;
            end
            if (in_valid && in_ready) begin
                k++;
                if (k == n * n) sb.push_back('{vecs[v].exp_det, vecs[v].exp_ovf});
            end
            @(negedge clock);
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        check($sformatf("v%0d load_timeout", v), (cyc >= 200), 1'b0);
        check($sformatf("v%0d in_ready_drop", v), in_ready, 1'b0);
        check($sformatf("v%0d busy_settle", v), busy, 1'b1);
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        in_valid = 1'b0;
        check($sformatf("v%0d result_latency", v), lat, LAT + 1);
        check($sformatf("v%0d A_flat", v), A_flat, embed(v));
        if (sb.size() == 0) begin
            check($sformatf("v%0d scoreboard_empty", v), 1'b1, 1'b0);
        end else begin
            e = sb[0];
            res_ready = 1'b0;
            for (int h = 0; h < vecs[v].hold; h++) begin
                check($sformatf("v%0d hold%0d res_valid", v, h), res_valid, 1'b1);
                check($sformatf("v%0d hold%0d res_det", v, h), res_det, e.det);
                check($sformatf("v%0d hold%0d res_overflow", v, h), res_overflow, e.ovf);
                @(negedge clock);
            end
            check($sformatf("v%0d res_det", v), res_det, e.det);
            check($sformatf("v%0d res_overflow", v), res_overflow, e.ovf);
            res_ready = 1'b1;
            if (vecs[v].poke_start) begin
                start = 1'b1; mat_size = 3'd2;
            end
            @(negedge clock);
            void'(sb.pop_front());
            res_ready = 1'b0;
            start     = 1'b0;
            check($sformatf("v%0d busy_after_accept", v), busy, 1'b0);
            check($sformatf("v%0d res_valid_after_accept", v), res_valid, 1'b0);
            check($sformatf("v%0d in_ready_idle", v), in_ready, 1'b0);
            @(negedge clock);
            check($sformatf("v%0d still_idle", v), busy, 1'b0);
            check($sformatf("v%0d A_flat_kept", v), A_flat, embed(v));
        end
    endtask

    task automatic check_size_error(input logic [2:0] s, input logic [199:0] prev_a);
        start = 1'b1; mat_size = s;
        @(negedge clock);
        start = 1'b0;
        check($sformatf("size%0d size_error_pulse", s), size_error, 1'b1);
        check($sformatf("size%0d busy", s), busy, 1'b0);
        check($sformatf("size%0d in_ready", s), in_ready, 1'b0);
        check($sformatf("size%0d A_flat", s), A_flat, prev_a);
        @(negedge clock);
        check($sformatf("size%0d size_error_clear", s), size_error, 1'b0);
        check($sformatf("size%0d busy_after", s), busy, 1'b0);
    endtask

    task automatic check_idle_reset_values(input string tag);
        check({tag, " A_flat"}, A_flat, ident());
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " in_ready"}, in_ready, 1'b0);
        check({tag, " res_valid"}, res_valid, 1'b0);
        check({tag, " size_error"}, size_error, 1'b0);
        check({tag, " res_det"}, res_det, 8'h00);
        check({tag, " res_overflow"}, res_overflow, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int v = 0; v < 5; v++)
            for (int k = 0; k < 25; k++) el[v][k] = 8'h00;
        vecs[0] = '{2, 8'h0A, 1'b0, 1'b0, 0, 1'b0};
        el[0][0] = 8'd3; el[0][1] = 8'd1; el[0][2] = 8'd2; el[0][3] = 8'd4;
        vecs[1] = '{5, 8'h01, 1'b0, 1'b0, 0, 1'b1};
        for (int r = 0; r < 5; r++) el[1][6*r] = 8'd1;
        vecs[2] = '{3, 8'hE8, 1'b1, 1'b0, 0, 1'b0};
        el[2][0] = 8'd10; el[2][4] = 8'd10; el[2][8] = 8'd10;
        vecs[3] = '{4, 8'hE2, 1'b0, 1'b1, 5, 1'b0};
        el[3][0]  = 8'd1; el[3][1] = 8'd2; el[3][2] = 8'd3; el[3][3] = 8'd4;
        el[3][5]  = 8'hFE; el[3][6] = 8'd1; el[3][7] = 8'd1;
        el[3][10] = 8'd3; el[3][11] = 8'd2; el[3][15] = 8'd5;
        vecs[4] = '{2, 8'hFE, 1'b0, 1'b0, 0, 1'b0};
        el[4][0] = 8'd1; el[4][1] = 8'd2; el[4][2] = 8'd3; el[4][3] = 8'd4;

        reset = 1'b1; start = 1'b0; mat_size = 3'd0;
        in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_idle_reset_values("reset");
        reset = 1'b0;
        @(negedge clock);

        for (int v = 0; v < 4; v++) run_vec(v);

        check_size_error(3'd1, embed(3));
        check_size_error(3'd6, embed(3));

        // Abort a 3x3 load after 7 elements with reset.
        start = 1'b1; mat_size = 3'd3;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; in_data = 8'(k + 20);
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("abort busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check_idle_reset_values("abort");
        reset = 1'b0;
        @(negedge clock);
        check("abort still_idle", busy, 1'b0);
        run_vec(4);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
